egress_stage: RTL
=================

EGRESS_STAGE -- requirements
Module: egress_stage

Interface
REQ-001 Parameter NUM_REQS, default 4, number of arbitrated FIFOs/requestors.
REQ-002 Parameter WIDTH, default `FIFO_DWIDTH, packet width in bits.
REQ-003 Parameter IDWID, default $clog2(NUM_REQS), source-id width.
REQ-004 Parameter XCNTWID, default 16, transfer counter width.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 gnt  input  NUM_REQS  arbiter grant, equal to the pop vector of the upstream FIFOs.
REQ-008 flat_data_in  input  NUM_REQS*WIDTH  concatenated FIFO head data; slice i is [(i+1)*WIDTH-1:i*WIDTH].
REQ-009 out_rdy  input  1  downstream ready.
REQ-010 blk  output  1  backpressure to the arbiter blk input.
REQ-011 out_vld  output  1  egress data valid.
REQ-012 data_out  output  WIDTH  egress packet.
REQ-013 src_id  output  IDWID  index of the FIFO the egress packet came from.
REQ-014 xfer_cnt  output  XCNTWID  count of completed egress transfers.
REQ-015 err  output  1  sticky protocol-error flag.

Function
REQ-016 The block SHALL hold a 2-entry in-order buffer of {data, src_id}, with occupancy count 0..2.
REQ-017 Capture: when gnt is one-hot and blk=0, on that edge the block SHALL enqueue the flat_data_in slice selected by gnt, together with the gnt index. Latency is one cycle from gnt to earliest out_vld.
REQ-018 out_vld SHALL equal (count>0); data_out/src_id SHALL show the oldest entry and stay stable while out_vld=1 and out_rdy=0.
REQ-019 A transfer occurs when out_vld & out_rdy; the entry is dequeued on that edge and xfer_cnt increments by 1, wrapping from 2^XCNTWID-1 to 0.
REQ-020 Simultaneous capture and transfer SHALL leave count unchanged and preserve order: the new entry goes behind the remaining one.
REQ-021 blk SHALL be combinational and equal (count==2).
REQ-022 A gnt with more than one bit set SHALL set err, and nothing is enqueued.
REQ-023 Any nonzero gnt while blk=1 SHALL set err, and nothing is enqueued; count and buffer contents are unchanged apart from a concurrent transfer.
REQ-024 gnt==0 SHALL be a no-op for capture.
REQ-025 err SHALL remain set until reset.
REQ-026 Entry data SHALL be unaffected by flat_data_in changes after capture.

Reset
REQ-027 With rst=1 at a clock edge, count, xfer_cnt and err SHALL go to 0, so out_vld=0 and blk=0. This overrides any concurrent gnt or transfer, including a reset asserted mid-stall.
REQ-028 data_out and src_id SHALL be 0 while out_vld=0 after reset; buffer data is not otherwise required to be cleared.

Structure
REQ-029 Default WIDTH and NUM_REQS SHALL come from the shared options.v defines (`FIFO_DWIDTH); no new defines are added.
REQ-030 One-hot-to-index conversion SHALL reuse the existing pridec sub-module. The one-hot check is separate logic.
REQ-031 Buffer storage SHALL use the existing FF module for registers; no other sub-module.
REQ-032 Under `FORMAL, the block SHALL assert that count never exceeds 2 and that out_vld implies count>0.

Verification
REQ-033 Reset then gnt=4'b0100 with slice2=8'hA5, out_rdy=1 -> next cycle out_vld=1, data_out=A5, src_id=2; cycle after, out_vld=0, xfer_cnt=1.
REQ-034 out_rdy=0; gnt slice0=11 then slice3=22 on consecutive cycles -> blk=1 after the second; out_rdy=1 -> outputs 11 (id0) then 22 (id3) in order, blk drops after the first transfer.
REQ-035 count=1 (entry 33) and out_rdy=1 with gnt=0001 (data 44) same cycle -> count stays 1, next data_out=44, no err.
REQ-036 gnt=0011 -> err=1, count unchanged; gnt while blk=1 -> err=1, buffer unchanged; err stays 1 until rst.
REQ-037 Preset xfer_cnt to 16'hFFFF via 65535 transfers, then one more transfer -> xfer_cnt=0.
REQ-038 rst asserted with count=2 and out_rdy=0 -> next cycle out_vld=0, blk=0, err=0, xfer_cnt=0.

Source files
------------

// File: rtl/egress_stage_pkg.sv
// egress_stage_pkg
//   Shared types and helpers for the egress stage: the occupancy type of the
//   two-entry output buffer and the occupancy update rule.
package egress_stage_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_FULL  = 2'd2;

  // Occupancy after one edge: a capture adds one, a transfer removes one.
  // Both together leave the count unchanged.
  function automatic occ_t next_occ(input occ_t cur, input logic enq, input logic deq);
    return occ_t'(cur + occ_t'(enq) - occ_t'(deq));
  endfunction

endpackage

// File: rtl/FF.sv
// FF
//   Plain enabled register without reset, used for datapath storage whose
//   contents are only meaningful while qualified by a separate valid/count.
//   Ports:
//     clk   in  1  clock
//     i_en  in  1  load enable
//     i_d   in  W  next value
//     o_q   out W  stored value
module FF #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pridec.sv
// pridec
//   One-hot (or general request) vector to index. The lowest set bit wins, so
//   the result is well defined even for a vector that is not one-hot.
//   Ports:
//     i_onehot  in  N    request vector
//     o_idx     out IDW  index of the lowest set bit (0 when none set)
module pridec #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_onehot,
  output logic [IDW-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_onehot[i]) begin
        o_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/egress_stage.sv
// egress_stage
//   Captures the FIFO head selected by the arbiter grant into a 2-entry
//   in-order buffer and presents it downstream with valid/ready handshaking.
//   Ports:
//     clk           in  1               clock
//     rst           in  1               synchronous active-high reset
//     gnt           in  NUM_REQS        arbiter grant (= upstream FIFO pops)
//     flat_data_in  in  NUM_REQS*WIDTH  concatenated FIFO head data
//     out_rdy       in  1               downstream ready
//     blk           out 1               backpressure to arbiter (buffer full)
//     out_vld       out 1               egress data valid
//     data_out      out WIDTH           oldest buffered packet
//     src_id        out IDWID           FIFO index of data_out
//     xfer_cnt      out XCNTWID         completed transfers (wrapping)
//     err           out 1               sticky protocol error
`ifndef FIFO_DWIDTH
  // Normally supplied by the shared options.v; fallback for standalone builds.
  `define FIFO_DWIDTH 8
`endif

module egress_stage
  import egress_stage_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int WIDTH    = `FIFO_DWIDTH,
  parameter int IDWID    = $clog2(NUM_REQS),
  parameter int XCNTWID  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQS-1:0]       gnt,
  input  logic [NUM_REQS*WIDTH-1:0] flat_data_in,
  input  logic                      out_rdy,
  output logic                      blk,
  output logic                      out_vld,
  output logic [WIDTH-1:0]          data_out,
  output logic [IDWID-1:0]          src_id,
  output logic [XCNTWID-1:0]        xfer_cnt,
  output logic                      err
);

  localparam int EW = WIDTH + IDWID;  // entry = {data, src_id}

  occ_t               r_count;
  logic [XCNTWID-1:0] r_xfer_cnt;
  logic               r_err;

  logic [WIDTH-1:0] w_slice [NUM_REQS];
  logic [IDWID-1:0] w_idx;
  logic             w_onehot;
  logic             w_full;
  logic             w_vld;
  logic             w_enq;
  logic             w_deq;
  logic             w_bad;
  logic             w_wr_slot0;
  logic [EW-1:0]    w_new;
  logic [EW-1:0]    w_q  [BUF_DEPTH];
  logic [EW-1:0]    w_d  [BUF_DEPTH];
  logic             w_en [BUF_DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQS; gi++) begin : g_slice
      assign w_slice[gi] = flat_data_in[gi*WIDTH +: WIDTH];
    end
  endgenerate

  pridec #(
    .N   (NUM_REQS),
    .IDW (IDWID)
  ) u_pridec (
    .i_onehot (gnt),
    .o_idx    (w_idx)
  );

  // Clearing the lowest set bit leaves zero only for a single-bit vector.
  assign w_onehot = (gnt != '0) && ((gnt & (gnt - NUM_REQS'(1))) == '0);

  assign w_full = (r_count == OCC_FULL);
  assign w_vld  = (r_count != OCC_EMPTY);
  assign w_deq  = w_vld & out_rdy;
  assign w_enq  = w_onehot & ~w_full;
  assign w_bad  = (gnt != '0) & (~w_onehot | w_full);
  assign w_new  = {w_slice[w_idx], w_idx};

  // Slot 0 is the head. A new entry lands in the first slot that is free
  // after this edge's transfer, which keeps it behind any surviving entry.
  assign w_wr_slot0 = (r_count == OCC_EMPTY) || ((r_count == occ_t'(1)) && w_deq);

  always_comb begin
    w_en[0] = 1'b0;
    w_d[0]  = w_new;
    w_en[1] = w_enq & ~w_wr_slot0;
    w_d[1]  = w_new;
    if (w_deq && w_full) begin
      // Full buffer drains: the second entry moves up to the head.
      w_en[0] = 1'b1;
      w_d[0]  = w_q[1];
    end else if (w_enq && w_wr_slot0) begin
      w_en[0] = 1'b1;
    end
  end

  generate
    for (gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
      FF #(.W(EW)) u_slot (
        .clk  (clk),
        .i_en (w_en[gi]),
        .i_d  (w_d[gi]),
        .o_q  (w_q[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= OCC_EMPTY;
      r_xfer_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_count <= next_occ(r_count, w_enq, w_deq);
      if (w_deq) begin
        r_xfer_cnt <= r_xfer_cnt + XCNTWID'(1);
      end
      if (w_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  assign blk      = w_full;
  assign out_vld  = w_vld;
  // Buffer storage is never cleared, so mask the outputs while empty.
  assign data_out = w_vld ? w_q[0][EW-1:IDWID] : '0;
  assign src_id   = w_vld ? w_q[0][IDWID-1:0]  : '0;
  assign xfer_cnt = r_xfer_cnt;
  assign err      = r_err;

`ifdef FORMAL
  always_comb begin
    assert (r_count <= OCC_FULL);
    assert (!out_vld || (r_count != OCC_EMPTY));
  end
`endif

endmodule
